qf_to_bcd: RTL and testbench

Sequential converter from unsigned fixed-point Q.F binary to packed BCD for display. Sits directly downstream of the Q.F divider: its `st` is driven by the divider's `ok_div`, and its `Q`/`F` by the divider's quotient outputs. Integer part is converted by shift-add-3 (double-dabble); fractional part by repeated multiply-by-10. Outputs feed the 7-segment display multiplexer.

---
 rtl/qf_to_bcd_pkg.sv | 32 +++
 rtl/qf_to_bcd_dig.sv | 35 +++
 rtl/qf_to_bcd.sv | 197 +++++++++++++++++++
 tb/tb_qf_to_bcd.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/qf_to_bcd_pkg.sv
// rtl/qf_to_bcd_pkg.sv - shared constants and FSM encoding for the Q.F to BCD converter
// Holds the default widths (matching the upstream Q.F divider), digit counts,
// the nibble-cell mode codes and the converter state encoding.
// Optional feature macro: QF_BCD_ROUND_EN (adds a guard digit and a rounding state).
package qf_to_bcd_pkg;

    // Widths of the divider quotient that feeds this block
    localparam int QF_M_A_DEF   = 8;
    localparam int QF_M_B_DEF   = 8;
    // Display digit counts
    localparam int QF_N_INT_DEF = 3;
    localparam int QF_N_FRC_DEF = 3;

`ifdef QF_BCD_ROUND_EN
    localparam int QF_ROUND = 1;
`else
    localparam int QF_ROUND = 0;
`endif

    // bcd_dig_adj operating modes
    localparam logic DIG_ADD3 = 1'b0;
    localparam logic DIG_INC  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INT  = 3'd1,
        ST_FRC  = 3'd2,
        ST_RND  = 3'd3,
        ST_DONE = 3'd4
    } qf_state_e;

endpackage

// File: rtl/qf_to_bcd_dig.sv
// rtl/qf_to_bcd_dig.sv - bcd_dig_adj: combinational 4-bit BCD nibble cell
// Ports:
//   mode  in  DIG_ADD3 (din>=5 ? din+3 : din) or DIG_INC (din+cin mod 10)
//   din   in  input nibble
//   cin   in  decimal carry in (inc mode only)
//   dout  out adjusted nibble
//   cout  out decimal carry out (inc mode only, 0 in add3 mode)
module bcd_dig_adj
    import qf_to_bcd_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] din,
    input  logic       cin,
    output logic [3:0] dout,
    output logic       cout
);

    always_comb begin
        dout = din;
        cout = 1'b0;
        if (mode == DIG_ADD3) begin
            if (din >= 4'd5) begin
                dout = din + 4'd3;
            end
        end else if (cin) begin
            if (din >= 4'd9) begin
                dout = 4'd0;
                cout = 1'b1;
            end else begin
                dout = din + 4'd1;
            end
        end
    end

endmodule

// File: rtl/qf_to_bcd.sv
// rtl/qf_to_bcd.sv - sequential unsigned Q.F binary to packed BCD converter
// Integer part by shift-add-3, fraction by repeated multiply-by-10.
// Optional feature macro: QF_BCD_ROUND_EN (round to nearest on a guard digit).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   st                 one-cycle start, captures Q/F (restarts if busy)
//   Q [M_A], F [M_B]   integer part and fraction (value F/2^M_B)
//   bcd_int [4*N_INT]  integer digits, MSD in top nibble
//   bcd_frc [4*N_FRC]  fraction digits, tenths in top nibble
//   ok_bcd             one-cycle done pulse
//   busy               conversion in progress
//   ovf                integer part does not fit in N_INT digits
module qf_to_bcd
    import qf_to_bcd_pkg::*;
#(
    parameter int M_A   = QF_M_A_DEF,
    parameter int M_B   = QF_M_B_DEF,
    parameter int N_INT = QF_N_INT_DEF,
    parameter int N_FRC = QF_N_FRC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 st,
    input  logic [M_A-1:0]       Q,
    input  logic [M_B-1:0]       F,
    output logic [4*N_INT-1:0]   bcd_int,
    output logic [4*N_FRC-1:0]   bcd_frc,
    output logic                 ok_bcd,
    output logic                 busy,
    output logic                 ovf
);

    // With rounding the fraction accumulator carries one extra guard digit at the bottom
    localparam int FRC_DIG = N_FRC + QF_ROUND;
    localparam int IW      = 4 * N_INT;
    localparam int FW      = 4 * FRC_DIG;
    localparam logic [31:0] INT_LIMIT = 32'(10 ** N_INT);

    qf_state_e          state_q, state_d;
    logic [M_A-1:0]     sq_q, sq_d;
    logic [M_B-1:0]     rf_q, rf_d;
    logic [IW-1:0]      iacc_q, iacc_d;
    logic [FW-1:0]      facc_q, facc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [IW-1:0]      bcd_int_q, bcd_int_d;
    logic [4*N_FRC-1:0] bcd_frc_q, bcd_frc_d;
    logic               ok_bcd_q, ok_bcd_d;
    logic               ovf_q, ovf_d;

    logic [IW-1:0]      iacc_adj;
    logic [N_INT-1:0]   unused_add3_co;
    logic [M_B+3:0]     p;

    // Shift-add-3 correction of every integer digit before each shift
    for (genvar g = 0; g < N_INT; g++) begin : g_add3
        bcd_dig_adj u_add3 (
            .mode (DIG_ADD3),
            .din  (iacc_q[4*g +: 4]),
            .cin  (1'b0),
            .dout (iacc_adj[4*g +: 4]),
            .cout (unused_add3_co[g])
        );
    end

    // rf*10 as (rf<<3)+(rf<<1); the top nibble is the next decimal digit
    assign p = ({4'b0000, rf_q} << 3) + ({4'b0000, rf_q} << 1);

`ifdef QF_BCD_ROUND_EN
    localparam int RD = N_INT + N_FRC;
    logic [4*RD-1:0] rnd_in, rnd_out;
    logic [RD:0]     rnd_c;

    assign rnd_in   = {iacc_q, facc_q[FW-1:4]};
    assign rnd_c[0] = (facc_q[3:0] >= 4'd5);

    // Decimal ripple increment across {int, frc}, seeded by the guard digit
    for (genvar g = 0; g < RD; g++) begin : g_rnd
        bcd_dig_adj u_inc (
            .mode (DIG_INC),
            .din  (rnd_in[4*g +: 4]),
            .cin  (rnd_c[g]),
            .dout (rnd_out[4*g +: 4]),
            .cout (rnd_c[g+1])
        );
    end
`endif

    always_comb begin
        state_d   = state_q;
        sq_d      = sq_q;
        rf_d      = rf_q;
        iacc_d    = iacc_q;
        facc_d    = facc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_int_d = bcd_int_q;
        bcd_frc_d = bcd_frc_q;
        ovf_d     = ovf_q;
        ok_bcd_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
            end
            ST_INT: begin
                // Carry out of the top digit is dropped from the digits but remembered as overflow
                iacc_d    = {iacc_adj[IW-2:0], sq_q[M_A-1]};
                sq_d      = sq_q << 1;
                ovf_acc_d = ovf_acc_q | iacc_adj[IW-1];
                if (cnt_q == 8'(M_A - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_FRC;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_FRC: begin
                facc_d = {facc_q[FW-5:0], p[M_B+3:M_B]};
                rf_d   = p[M_B-1:0];
                if (cnt_q == 8'(FRC_DIG - 1)) begin
                    cnt_d = '0;
`ifdef QF_BCD_ROUND_EN
                    state_d = ST_RND;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`ifdef QF_BCD_ROUND_EN
            ST_RND: begin
                {iacc_d, facc_d[FW-1:4]} = rnd_out;
                ovf_acc_d = ovf_acc_q | rnd_c[RD];
                state_d   = ST_DONE;
            end
`endif
            ST_DONE: begin
                bcd_int_d = iacc_q;
                bcd_frc_d = facc_q[FW-1:FW-4*N_FRC];
                ovf_d     = ovf_acc_q;
                ok_bcd_d  = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A start always wins: it aborts any conversion in flight, but the
        // DONE output load above still happens if it coincides with DONE
        if (st) begin
            sq_d      = Q;
            rf_d      = F;
            iacc_d    = '0;
            facc_d    = '0;
            cnt_d     = '0;
            ovf_acc_d = (32'(Q) >= INT_LIMIT);
            state_d   = ST_INT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sq_q      <= '0;
            rf_q      <= '0;
            iacc_q    <= '0;
            facc_q    <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_int_q <= '0;
            bcd_frc_q <= '0;
            ok_bcd_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sq_q      <= sq_d;
            rf_q      <= rf_d;
            iacc_q    <= iacc_d;
            facc_q    <= facc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_int_q <= bcd_int_d;
            bcd_frc_q <= bcd_frc_d;
            ok_bcd_q  <= ok_bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bcd_int = bcd_int_q;
    assign bcd_frc = bcd_frc_q;
    assign ok_bcd  = ok_bcd_q;
    assign ovf     = ovf_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qf_to_bcd.sv
// tb/tb_qf_to_bcd.sv - scoreboard bench for qf_to_bcd (3- and 2-digit integer instances)
module tb_qf_to_bcd;

    localparam int NF = 3;
    localparam int MB = 8;
`ifdef QF_BCD_ROUND_EN
    localparam int LAT = 14;
`else
    localparam int LAT = 12;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st = 1'b0;
    logic [7:0]  q_in = '0;
    logic [7:0]  f_in = '0;

    logic [11:0] bi1, bf1;
    logic        ok1, busy1, ovf1;
    logic [7:0]  bi2;
    logic [11:0] bf2;
    logic        ok2, busy2, ovf2;

    qf_to_bcd dut1 (
        .clk(clk), .rst_n(rst_n), .st(st), .Q(q_in), .F(f_in),
        .bcd_int(bi1), .bcd_frc(bf1), .ok_bcd(ok1), .busy(busy1), .ovf(ovf1)
    );

    qf_to_bcd #(.N_INT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .st(st), .Q(q_in), .F(f_in),
        .bcd_int(bi2), .bcd_frc(bf2), .ok_bcd(ok2), .busy(busy2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] bi;
        logic [11:0] bf;
        logic        ov;
        int          at;
    } exp_t;

    exp_t sb1[$];
    exp_t sb2[$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 0;
    int   last_k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int unsigned v, input int n);
        logic [11:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Decimal value of Q + F/256, truncated or rounded to NF places
    function automatic exp_t model(input int unsigned qv, input int unsigned fv, input int n_int, input int at);
        exp_t        m;
        int unsigned pn, pf, r, x, total;
        pn = 10 ** n_int;
        pf = 10 ** NF;
`ifdef QF_BCD_ROUND_EN
        x = (fv * pf * 10) >> MB;
        r = x / 10 + (((x % 10) >= 5) ? 1 : 0);
`else
        x = 0;
        r = (fv * pf) >> MB;
`endif
        total = qv * pf + r + x * 0;
        m.ov = (total >= pn * pf);
        m.bi = to_bcd((total / pf) % pn, n_int);
        m.bf = to_bcd(total % pf, NF);
        m.at = at;
        return m;
    endfunction

    task automatic start(input int qv, input int fv);
        int k;
        k = cyc + 1;
        if (started && (k - last_k) < LAT) begin
            if (sb1.size() > 0) sb1.delete(sb1.size() - 1);
            if (sb2.size() > 0) sb2.delete(sb2.size() - 1);
        end
        sb1.push_back(model(qv, fv, 3, k + LAT));
        sb2.push_back(model(qv, fv, 2, k + LAT));
        started = 1;
        last_k  = k;
        q_in    = 8'(qv);
        f_in    = 8'(fv);
        st      = 1'b1;
        @(negedge clk);
        st = 1'b0;
        chk("busy_after_st", 32'(busy1), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (sb1.size() + sb2.size()) > 0; i++) @(negedge clk);
        checks++;
        if ((sb1.size() + sb2.size()) > 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", sb1.size() + sb2.size());
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ok1) begin
            if (sb1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ok1_unexpected got 1 expected 0 at cycle %0d", cyc);
            end else begin
                e = sb1.pop_front();
                chk("n3_bcd_int", 32'(bi1), 32'(e.bi));
                chk("n3_bcd_frc", 32'(bf1), 32'(e.bf));
                chk("n3_ovf", 32'(ovf1), 32'(e.ov));
                chk("n3_done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ok2) begin
            if (sb2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ok2_unexpected got 1 expected 0 at cycle %0d", cyc);
            end else begin
                e = sb2.pop_front();
                chk("n2_bcd_int", 32'(bi2), 32'(e.bi));
                chk("n2_bcd_frc", 32'(bf2), 32'(e.bf));
                chk("n2_ovf", 32'(ovf2), 32'(e.ov));
                chk("n2_done_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    int dir_q[8] = '{123, 0, 255, 1, 150, 99, 7, 100};
    int dir_f[8] = '{8'h80, 8'h00, 8'hFF, 8'h01, 8'h40, 8'hFF, 8'h1A, 8'h08};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_bcd_int", 32'(bi1), 32'd0);
        chk("rst_bcd_frc", 32'(bf1), 32'd0);
        chk("rst_ok_bcd", 32'(ok1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ovf", 32'(ovf1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            start(dir_q[i], dir_f[i]);
            repeat (LAT + 1) @(negedge clk);
            chk("busy_idle", 32'(busy1), 32'd0);
        end

        // Restart while busy: only the second conversion completes
        start(10, 8'h33);
        repeat (4) @(negedge clk);
        start(20, 8'h10);
        repeat (LAT + 1) @(negedge clk);

        // New start on the same edge as DONE
        start(45, 8'h20);
        repeat (LAT - 1) @(negedge clk);
        start(67, 8'hC0);
        repeat (LAT + 1) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            start(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            repeat ($urandom_range(0, LAT + 2)) @(negedge clk);
        end
        drain();

        // Asynchronous reset in the middle of a conversion
        start(255, 8'hFF);
        repeat (LAT + 1) @(negedge clk);
        start(77, 8'h55);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb1.delete();
        sb2.delete();
        started = 0;
        #1;
        chk("arst_busy", 32'(busy1), 32'd0);
        chk("arst_bcd_int", 32'(bi1), 32'd0);
        chk("arst_bcd_frc", 32'(bf1), 32'd0);
        chk("arst_ok_bcd", 32'(ok1), 32'd0);
        chk("arst_ovf", 32'(ovf1), 32'd0);
        chk("arst_n2_bcd_int", 32'(bi2), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) @(negedge clk);

        start(200, 8'h99);
        repeat (LAT + 1) @(negedge clk);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
